// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM encoding,
// fetch source selection and default widths.
package instr_fetch_pkg;

    localparam int PC_W_DEF      = 16;
    localparam int INSTR_W_DEF   = 32;
    localparam int BUF_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_ISSUE    = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ROM_WAIT = 2'd2,
        ST_DRAIN    = 2'd3
    } fetch_state_e;

    typedef enum logic {
        SRC_ROM = 1'b0,
        SRC_MEM = 1'b1
    } fetch_src_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: mode inputs, redirect, external memory, boot ROM and
// decoder handoff. The fetch stage is the master; its environment is the slave.
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               boot_mode;
    logic               instr_mem_over;
    logic               br_valid;
    logic [PC_W-1:0]    br_target;
    logic               mem_req;
    logic [PC_W:0]      mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_data;
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               if_ready;

    modport master (
        input  boot_mode, instr_mem_over, br_valid, br_target,
        input  mem_ack, mem_data, rom_data, if_ready,
        output mem_req, mem_addr, rom_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output boot_mode, instr_mem_over, br_valid, br_target,
        output mem_ack, mem_data, rom_data, if_ready,
        input  mem_req, mem_addr, rom_addr, if_valid, if_instr, if_pc
    );

endinterface

// File: rtl/instr_fetch_buf.sv
// Prefetch FIFO: synchronous, power-of-two depth, flush clears all entries.
// No bypass: a pushed word becomes visible at the head on the following cycle.
module instr_fetch_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    wptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rptr_q];

    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // NOTE: storage is deliberately not reset; the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, fetch FSM choosing boot ROM or external memory,
// and a prefetch buffer flushed on every redirect.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam int ENTRY_W = INSTR_W + PC_W;

    fetch_state_e       state_q, state_d;
    fetch_src_e         src_q, src_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    issued_pc_q, issued_pc_d;
    logic [PC_W:0]      mem_addr_q, mem_addr_d;

    logic               push;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;
    logic               pop;
    logic               empty;
    logic               full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ISSUE;
            src_q       <= SRC_ROM;
            pc_q        <= '0;
            issued_pc_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        mem_addr_d  = mem_addr_q;
        push        = 1'b0;
        push_data   = {bus.rom_data, issued_pc_q};

        case (state_q)
            ST_ISSUE: begin
                // Only one fetch is ever in flight, so a free slot now is a free slot at push.
                if (!full && !bus.br_valid) begin
                    issued_pc_d = pc_q;
                    pc_d        = pc_q + 1'b1;
                    if (src_q == SRC_MEM) begin
                        mem_addr_d = {bus.instr_mem_over, pc_q};
                        state_d    = ST_MEM_WAIT;
                    end else begin
                        state_d    = ST_ROM_WAIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                push_data = {bus.mem_data, issued_pc_q};
                if (bus.mem_ack) begin
                    push    = !bus.br_valid;
                    state_d = ST_ISSUE;
                end else if (bus.br_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_ROM_WAIT: begin
                push    = !bus.br_valid;
                state_d = ST_ISSUE;
            end
            ST_DRAIN: begin
                if (bus.mem_ack) state_d = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
        endcase

        // A redirect is also where a pending boot-mode change is committed.
        if (bus.br_valid) begin
            pc_d  = bus.br_target;
            src_d = bus.boot_mode ? SRC_ROM : SRC_MEM;
        end
    end

    assign pop = bus.if_valid && bus.if_ready;

    instr_fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (bus.br_valid),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (empty),
        .full_o      (full)
    );

    // The ROM is synchronous, so it must see the PC during the issue cycle itself.
    assign bus.rom_addr = pc_q;
    assign bus.mem_req  = (state_q == ST_MEM_WAIT) || (state_q == ST_DRAIN);
    assign bus.mem_addr = mem_addr_q;
    assign bus.if_valid = !empty;
    assign bus.if_instr = head[ENTRY_W-1:PC_W];
    assign bus.if_pc    = head[PC_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: boot-ROM streaming, external fetch, back-pressure,
// redirects during a request, PC wrap and reset mid-request.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic rom_phase;
    logic mem_req_seen;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous boot ROM: word = 0xA000_0000 | address, one cycle latency.
    always @(posedge clk) bus.rom_data <= 32'hA000_0000 | {16'h0, bus.rom_addr};

    always @(negedge clk) begin
        if (rom_phase && bus.mem_req === 1'b1) mem_req_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_cycle(input logic [31:0] d);
        bus.mem_ack  = 1'b1;
        bus.mem_data = d;
        tick();
        bus.mem_ack  = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rom_phase      = 1'b0;
        mem_req_seen   = 1'b0;
        rst_n          = 1'b0;
        bus.boot_mode  = 1'b1;
        bus.instr_mem_over = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_target  = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_data   = '0;
        bus.if_ready   = 1'b1;

        repeat (2) tick();
        check("reset_if_valid", bus.if_valid, 0);
        check("reset_mem_req", bus.mem_req, 0);
        check("reset_rom_addr", bus.rom_addr, 0);

        // Boot ROM streaming: one word every two cycles.
        rst_n     = 1'b1;
        rom_phase = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rom_addr_%0d", k), bus.rom_addr, k);
            tick();
            tick();
            check($sformatf("rom_valid_%0d", k), bus.if_valid, 1);
            check($sformatf("rom_pc_%0d", k), bus.if_pc, k);
            check($sformatf("rom_instr_%0d", k), bus.if_instr, 32'hA000_0000 | k);
        end
        rom_phase = 1'b0;
        check("rom_no_mem_req", mem_req_seen, 0);

        // Redirect into external memory, upper page.
        bus.br_target      = 16'h0100;
        bus.boot_mode      = 1'b0;
        bus.instr_mem_over = 1'b1;
        bus.br_valid       = 1'b1;
        tick();
        bus.br_valid = 1'b0;
        check("redir_flush_valid", bus.if_valid, 0);
        check("redir_no_req", bus.mem_req, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mem_req_hold_%0d", k), bus.mem_req, 1);
            check($sformatf("mem_addr_hold_%0d", k), bus.mem_addr, 17'h10100);
        end
        ack_cycle(32'hB000_0100);
        check("mem_req_dropped", bus.mem_req, 0);
        check("mem_valid", bus.if_valid, 1);
        check("mem_pc", bus.if_pc, 16'h0100);
        check("mem_instr", bus.if_instr, 32'hB000_0100);
        tick();
        check("mem_next_req", bus.mem_req, 1);
        check("mem_next_addr", bus.mem_addr, 17'h10101);

        // Back-pressure: fill both slots, then no further request.
        bus.if_ready = 1'b0;
        ack_cycle(32'hB000_0101);
        tick();
        check("fill_addr", bus.mem_addr, 17'h10102);
        ack_cycle(32'hB000_0102);
        check("full_valid", bus.if_valid, 1);
        check("full_head", bus.if_pc, 16'h0101);
        check("full_no_req_0", bus.mem_req, 0);
        tick();
        check("full_no_req_1", bus.mem_req, 0);
        tick();
        check("full_no_req_2", bus.mem_req, 0);
        check("full_head_kept", bus.if_instr, 32'hB000_0101);
        bus.if_ready = 1'b1;
        tick();
        check("drain_pc_1", bus.if_pc, 16'h0102);
        check("drain_instr_1", bus.if_instr, 32'hB000_0102);
        check("drain_no_req", bus.mem_req, 0);
        tick();
        check("drain_empty", bus.if_valid, 0);
        check("drain_resume_req", bus.mem_req, 1);
        check("drain_resume_addr", bus.mem_addr, 17'h10103);

        // Redirect while a request is outstanding: request held, late word discarded.
        bus.br_target = 16'h0040;
        bus.br_valid  = 1'b1;
        tick();
        bus.br_valid = 1'b0;
        check("drain_req_held", bus.mem_req, 1);
        check("drain_addr_held", bus.mem_addr, 17'h10103);
        check("drain_valid_low", bus.if_valid, 0);
        tick();
        check("drain_req_held_2", bus.mem_req, 1);
        ack_cycle(32'hB000_0103);
        check("late_ack_req_low", bus.mem_req, 0);
        check("late_ack_discarded", bus.if_valid, 0);
        bus.instr_mem_over = 1'b0;
        tick();
        check("target_req", bus.mem_req, 1);
        check("target_addr", bus.mem_addr, 17'h00040);
        ack_cycle(32'hB000_0040);
        check("target_valid", bus.if_valid, 1);
        check("target_pc", bus.if_pc, 16'h0040);
        check("target_instr", bus.if_instr, 32'hB000_0040);
        tick();
        check("after_target_addr", bus.mem_addr, 17'h00041);

        // Redirect in the same cycle as the ack: word dropped.
        bus.br_target = 16'h0200;
        bus.br_valid  = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_data  = 32'hB000_0041;
        tick();
        bus.br_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        check("same_cycle_dropped", bus.if_valid, 0);
        check("same_cycle_req_low", bus.mem_req, 0);
        tick();
        check("same_cycle_next_addr", bus.mem_addr, 17'h00200);
        ack_cycle(32'hB000_0200);
        check("same_cycle_first_pc", bus.if_pc, 16'h0200);

        // PC wrap at the top of the address space.
        bus.br_target = 16'hFFFF;
        bus.br_valid  = 1'b1;
        tick();
        bus.br_valid = 1'b0;
        check("wrap_flush", bus.if_valid, 0);
        tick();
        check("wrap_top_addr", bus.mem_addr, 17'h0FFFF);
        ack_cycle(32'hB000_FFFF);
        check("wrap_top_pc", bus.if_pc, 16'hFFFF);
        bus.if_ready = 1'b0;
        tick();
        check("wrap_zero_addr", bus.mem_addr, 17'h00000);
        check("wrap_zero_req", bus.mem_req, 1);
        check("wrap_buf_valid", bus.if_valid, 1);

        // Reset while the request is outstanding.
        rst_n = 1'b0;
        tick();
        check("rst_mid_mem_req", bus.mem_req, 0);
        check("rst_mid_if_valid", bus.if_valid, 0);
        check("rst_mid_rom_addr", bus.rom_addr, 0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
